// File: rtl/seg7_scan4.sv
// seg7_scan4 -- 4-digit multiplexed 7-segment display driver.
// Snapshots four BCD digits plus decimal points once per frame, then scans
// them onto one shared segment bus. Each digit slot opens with an all-off
// gap to prevent ghosting. Optional leading-zero blanking applies to
// digits 3..1.
// Ports:
//   clk_i     clock, all state changes on its rising edge
//   reset_i   synchronous active-high reset, dominates every other input
//   en_i      scan enable; when low, the scan position holds and outputs go dark
//   d0_i..d3_i BCD digits (d0 least significant)
//   dp_i      decimal point per digit, dp_i[i] belongs to digit i
//   seg_o     segments a..g on bits 0..6 (pin polarity)
//   seg_dp_o  decimal-point segment (pin polarity)
//   dig_o     one-hot digit select (pin polarity)
//   frame_o   one-cycle pulse after the last clock of slot 3
module seg7_scan4 #(
   parameter int DIV            = 50000,
   parameter int BLANK          = 16,
   parameter int LZB            = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       en_i,
   input  logic [3:0] d0_i,
   input  logic [3:0] d1_i,
   input  logic [3:0] d2_i,
   input  logic [3:0] d3_i,
   input  logic [3:0] dp_i,
   output logic [6:0] seg_o,
   output logic       seg_dp_o,
   output logic [3:0] dig_o,
   output logic       frame_o
);

   localparam int            PW        = $clog2(DIV);
   localparam logic [PW-1:0] PCNT_MAX  = PW'(DIV - 1);
   localparam logic [PW-1:0] PCNT_BLNK = PW'(BLANK);
   localparam logic          SEG_INV   = (SEG_ACTIVE_LOW != 0);
   localparam logic          DIG_INV   = (DIG_ACTIVE_LOW != 0);
   localparam logic          LZB_ON    = (LZB != 0);
   localparam logic [6:0]    SEG_OFF   = SEG_INV ? 7'h7F : 7'h00;
   localparam logic          DP_OFF    = SEG_INV;
   localparam logic [3:0]    DIG_OFF   = DIG_INV ? 4'hF : 4'h0;

   // BCD to logical active-high segments (g..a); invalid codes show a dash
   function automatic logic [6:0] bcd_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic [1:0]      sidx_q, sidx_d;
   logic [3:0][3:0] sh_q, sh_d;
   logic [3:0]      sh_dp_q, sh_dp_d;
   logic [6:0]      seg_q, seg_d;
   logic            seg_dp_q, seg_dp_d;
   logic [3:0]      dig_q, dig_d;
   logic            frame_q, frame_d;
   logic            lz_blank_s;
   logic [6:0]      seg_log_s;

   // Leading-zero blanking for the current slot, judged on the snapshot only
   always_comb begin
      lz_blank_s = 1'b0;
      case (sidx_q)
         2'd3:    lz_blank_s = (sh_q[3] == 4'd0);
         2'd2:    lz_blank_s = (sh_q[3] == 4'd0) && (sh_q[2] == 4'd0);
         2'd1:    lz_blank_s = (sh_q[3] == 4'd0) && (sh_q[2] == 4'd0) && (sh_q[1] == 4'd0);
         default: lz_blank_s = 1'b0;
      endcase
      if (LZB_ON && lz_blank_s) begin
         seg_log_s = 7'h00;
      end else begin
         seg_log_s = bcd_decode(sh_q[sidx_q]);
      end
   end

   // Next-state: prescaler, slot index, frame snapshot and output phase
   always_comb begin
      pcnt_d   = pcnt_q;
      sidx_d   = sidx_q;
      sh_d     = sh_q;
      sh_dp_d  = sh_dp_q;
      seg_d    = SEG_OFF;
      seg_dp_d = DP_OFF;
      dig_d    = DIG_OFF;
      frame_d  = 1'b0;
      if (en_i) begin
         if (pcnt_q == PCNT_MAX) begin
            pcnt_d = {PW{1'b0}};
            sidx_d = sidx_q + 2'd1;
         end else begin
            pcnt_d = pcnt_q + PW'(1);
            sidx_d = sidx_q;
         end
         // Snapshot once per frame so a digit never tears mid-scan
         if ((pcnt_q == {PW{1'b0}}) && (sidx_q == 2'd0)) begin
            sh_d    = {d3_i, d2_i, d1_i, d0_i};
            sh_dp_d = dp_i;
         end else begin
            sh_d    = sh_q;
            sh_dp_d = sh_dp_q;
         end
         frame_d = (pcnt_q == PCNT_MAX) && (sidx_q == 2'd3);
         if (pcnt_q < PCNT_BLNK) begin
            seg_d    = SEG_OFF;
            seg_dp_d = DP_OFF;
            dig_d    = DIG_OFF;
         end else begin
            seg_d    = seg_log_s ^ {7{SEG_INV}};
            seg_dp_d = sh_dp_q[sidx_q] ^ SEG_INV;
            dig_d    = (4'b0001 << sidx_q) ^ {4{DIG_INV}};
         end
      end else begin
         frame_d = 1'b0;
      end
   end

   // State and registered pin outputs, synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pcnt_q   <= {PW{1'b0}};
         sidx_q   <= 2'd0;
         sh_q     <= 16'h0000;
         sh_dp_q  <= 4'h0;
         seg_q    <= SEG_OFF;
         seg_dp_q <= DP_OFF;
         dig_q    <= DIG_OFF;
         frame_q  <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         sidx_q   <= sidx_d;
         sh_q     <= sh_d;
         sh_dp_q  <= sh_dp_d;
         seg_q    <= seg_d;
         seg_dp_q <= seg_dp_d;
         dig_q    <= dig_d;
         frame_q  <= frame_d;
      end
   end

   assign seg_o    = seg_q;
   assign seg_dp_o = seg_dp_q;
   assign dig_o    = dig_q;
   assign frame_o  = frame_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboard bench for seg7_scan4 with DIV=8, BLANK=2, LZB=1, active-low pins.
// The stimulus process pushes the expected pin state for every clock it
// issues; the monitor pops and compares on each falling edge.
module tb_seg7_scan4;

   localparam int DIV   = 8;
   localparam int BLANK = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] d0, d1, d2, d3, dp;
   logic [6:0] seg;
   logic       seg_dp;
   logic [3:0] dig;
   logic       frame;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] dig;
      logic       frame;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   pos   = 0;   // enabled-clock position within the 32-clock frame

   always #5 clk = ~clk;

   seg7_scan4 #(
      .DIV(DIV), .BLANK(BLANK), .LZB(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) dut (
      .clk_i(clk), .reset_i(reset), .en_i(en),
      .d0_i(d0), .d1_i(d1), .d2_i(d2), .d3_i(d3), .dp_i(dp),
      .seg_o(seg), .seg_dp_o(seg_dp), .dig_o(dig), .frame_o(frame)
   );

   function automatic logic [3:0] dig_of(input int slot);
      case (slot)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   // one clock whose result must be all-inactive (reset or disabled)
   task automatic cyc_off();
      exp_t e;
      e.seg = 7'h7F; e.dp = 1'b1; e.dig = 4'hF; e.frame = 1'b0;
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   // n enabled clocks; segs/dps are the expected pin values per slot
   task automatic run(input int n, input logic [3:0][6:0] segs, input logic [3:0] dps);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if ((pos % DIV) < BLANK) begin
            e.seg = 7'h7F; e.dp = 1'b1; e.dig = 4'hF;
         end else begin
            e.seg = segs[pos / DIV]; e.dp = dps[pos / DIV]; e.dig = dig_of(pos / DIV);
         end
         e.frame = (pos == 4 * DIV - 1);
         q.push_back(e);
         @(posedge clk); #1;
         pos = (pos + 1) % (4 * DIV);
      end
   endtask

   // monitor: compare the registered outputs against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if ({seg, seg_dp, dig, frame} !== e) begin
               fails++;
               $display("FAIL out_cycle%0d got seg=%h dp=%b dig=%b frame=%b want seg=%h dp=%b dig=%b frame=%b",
                        tests, seg, seg_dp, dig, frame, e.seg, e.dp, e.dig, e.frame);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; en = 1'b1;
      d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; dp = 4'h0;
      // reset held 3 cycles, Reset beats En
      for (int i = 0; i < 3; i++) cyc_off();
      pos = 0;
      reset = 1'b0;
      // 1,2,3,4 across two frames: first cycle after release is still dark
      d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
      run(32, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
      run(32, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
      // change D0 in slot 2: invisible until the next frame
      run(16, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
      d0 = 4'd9;
      run(16, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
      run(32, {7'h79, 7'h24, 7'h30, 7'h10}, 4'hF);
      // leading-zero blanking
      d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd7;
      run(32, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF);
      d0 = 4'd0;
      run(32, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
      // invalid code shows dash and counts as nonzero; DP on digit 1
      d3 = 4'd1; d2 = 4'd0; d1 = 4'hA; d0 = 4'd0; dp = 4'b0010;
      run(32, {7'h79, 7'h40, 7'h3F, 7'h40}, 4'b1101);
      // drop En mid slot 1 for 5 clocks, then resume where it held
      run(11, {7'h79, 7'h40, 7'h3F, 7'h40}, 4'b1101);
      en = 1'b0;
      for (int i = 0; i < 5; i++) cyc_off();
      en = 1'b1;
      run(21, {7'h79, 7'h40, 7'h3F, 7'h40}, 4'b1101);
      run(20, {7'h79, 7'h40, 7'h3F, 7'h40}, 4'b1101);
      // reset mid slot 2, then a fresh snapshot from slot 0
      reset = 1'b1;
      d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4; dp = 4'h0;
      cyc_off();
      pos = 0;
      reset = 1'b0;
      run(32, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
      @(negedge clk); #1;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
